tk_sync_push_4ph: RTL and testbench

- Clocked-to-self-timed bridge feeding a Teak push channel built from the tkg_* gate library (C-elements, AO222, etc.).
- Accepts words on a synchronous valid/ready interface and buffers them in a small FIFO.
- Emits each word as a 4-phase bundled-data push: data, then req, then wait ack, then release.
- Sits directly upstream of a Teak handshake network. The async ack is synchronised into the clock domain.

---
 rtl/tk_sync_pkg.sv | 18 +
 rtl/tk_sync_ff.sv | 31 +++
 rtl/tk_sync_push_4ph.sv | 153 +++++++++++++++
 tb/tb_tk_sync_push_4ph.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tk_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tk_sync_pkg
// Brief    : Shared types and constants for the clocked-to-Teak push bridge.
// Revision : 1.0
// ============================================================================
package tk_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } tk_push_state_t;

  localparam int TK_SYNC_STAGES_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/tk_sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : tk_sync_ff
// Brief    : SYNC_STAGES-deep single-bit synchroniser, async active-low reset.
// Revision : 1.0
// ============================================================================
module tk_sync_ff
  import tk_sync_pkg::*;
#(
  parameter int SYNC_STAGES = TK_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tk_sync_push_4ph.sv
`default_nettype none
// ============================================================================
// Module   : tk_sync_push_4ph
// Brief    : Valid/ready FIFO feeding a 4-phase bundled-data Teak push channel.
// Revision : 1.0
// ============================================================================
module tk_sync_push_4ph
  import tk_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = TK_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             proto_err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] w_load_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_in_ready;
  logic               r_out_req;
  logic               r_proto_err;
  logic               w_ack_s;
  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic               w_req_nxt;
  tk_push_state_t     r_state;
  tk_push_state_t     w_state_nxt;

  tk_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (out_ack),
    .q       (w_ack_s)
  );

  assign w_push = in_valid && r_in_ready;

  // out_data only ever changes on the same edge that raises out_req
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_out_req;
    w_load      = 1'b0;
    w_load_ptr  = r_rd_ptr;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ_HI;
        end
      end
      REQ_HI: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!w_ack_s) begin
          w_pop = 1'b1;
          if (r_count > c_cnt_one) begin
            w_load      = 1'b1;
            w_load_ptr  = r_rd_ptr + c_ptr_one;
            w_req_nxt   = 1'b1;
            w_state_nxt = REQ_HI;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_out_req   <= 1'b0;
      r_out_data  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_req  <= w_req_nxt;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < c_depth);
      if (w_load) begin
        r_out_data <= r_mem[w_load_ptr];
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      // A synchronised ack with no request outstanding is flagged, not acted on
      if (w_ack_s && (r_state == IDLE)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_req   = r_out_req;
  assign out_data  = r_out_data;
  assign proto_err = r_proto_err;
  assign busy      = (r_count != '0) || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tk_sync_push_4ph.sv
`default_nettype none
// ============================================================================
// Module   : tb_tk_sync_push_4ph
// Brief    : Self-checking bench: cycle table, hand sequences, random stream.
// Revision : 1.0
// ============================================================================
module tb_tk_sync_push_4ph;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_req;
  logic             out_ack;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             proto_err;

  logic ack_m  = 1'b0;
  logic tb_ack = 1'b0;
  bit   resp_en   = 1'b0;
  bit   resp_rand = 1'b0;
  assign out_ack = ack_m | tb_ack;

  tk_sync_push_4ph #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int accepted  = 0;
  int delivered = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             prev_req = 1'b0;
  logic [WIDTH-1:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted word must appear once, in order, on a req rise
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      accepted++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("spurious_req", 32'(1), 32'(0));
      end else begin
        chk("deliver_data", 32'(out_data), 32'(exp_q.pop_front()));
        delivered++;
      end
      held = out_data;
    end else if (out_req && prev_req) begin
      chk("data_stable", 32'(out_data), 32'(held));
    end
    prev_req = out_req;
  end

  // Teak-side 4-phase responder with fixed or random turnaround
  always begin : p_resp
    int   dly;
    logic tgt;
    @(negedge clk);
    if (!resp_en) begin
      ack_m = 1'b0;
    end else if (out_req != ack_m) begin
      tgt = out_req;
      dly = resp_rand ? int'($urandom_range(0, 5)) : 3;
      repeat (dly) @(negedge clk);
      if (resp_en) ack_m = tgt;
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(0), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input logic v);
    int n = 0;
    while (out_req !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (out_req !== v) chk("wait_req_timeout", 32'(out_req), 32'(v));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("drain_timeout", 32'(busy), 32'(0));
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             ack;
    logic             rdy;
    logic             req;
    logic [WIDTH-1:0] dat;
    logic             bsy;
    logic             perr;
  } vec_t;

  function automatic vec_t mk(logic v, logic [WIDTH-1:0] d, logic ack, logic rdy,
                              logic req, logic [WIDTH-1:0] dat, logic bsy, logic perr);
    vec_t r;
    r.v = v; r.d = d; r.ack = ack; r.rdy = rdy;
    r.req = req; r.dat = dat; r.bsy = bsy; r.perr = perr;
    return r;
  endfunction

  vec_t tbl[17];

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int base;
    int low;

    // One word by hand-driven ack, then a 4-cycle stray ack while idle
    tbl[0]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 8'hA5, 0, 1, 0, 8'h00, 1, 0);
    tbl[2]  = mk(0, 8'h00, 0, 1, 1, 8'hA5, 1, 0);
    tbl[3]  = mk(0, 8'h00, 1, 1, 1, 8'hA5, 1, 0);
    tbl[4]  = mk(0, 8'h00, 1, 1, 1, 8'hA5, 1, 0);
    tbl[5]  = mk(0, 8'h00, 1, 1, 0, 8'hA5, 1, 0);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 0);
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 0);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 0);
    tbl[10] = mk(0, 8'h00, 1, 1, 0, 8'hA5, 0, 0);
    tbl[11] = mk(0, 8'h00, 1, 1, 0, 8'hA5, 0, 0);
    tbl[12] = mk(0, 8'h00, 1, 1, 0, 8'hA5, 0, 1);
    tbl[13] = mk(0, 8'h00, 1, 1, 0, 8'hA5, 0, 1);
    tbl[14] = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 1);
    tbl[15] = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 1);
    tbl[16] = mk(0, 8'h00, 0, 1, 0, 8'hA5, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_req", 32'(out_req), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_proto_err", 32'(proto_err), 32'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tb_ack   = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_out_req", i), 32'(out_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].dat));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_proto_err", i), 32'(proto_err), 32'(tbl[i].perr));
      @(negedge clk);
    end
    in_valid = 1'b0;
    tb_ack   = 1'b0;

    // Back-to-back: FIFO fills, third word waits, no idle gap between words
    resp_en = 1'b1;
    base = delivered;
    push_word(8'h01);
    push_word(8'h02);
    chk("b2b_full_ready", 32'(in_ready), 32'(0));
    fork
      push_word(8'h03);
      begin
        wait_req(1'b1);
        wait_req(1'b0);
        low = 0;
        while (!out_req && low < 100) begin
          @(negedge clk);
          low++;
        end
        chk("b2b_req_low_cycles", 32'(low), 32'(6));
      end
    join
    wait_idle();
    chk("b2b_delivered", 32'(delivered - base), 32'(3));
    chk("b2b_proto_err_sticky", 32'(proto_err), 32'(1));
    chk("b2b_idle_ready", 32'(in_ready), 32'(1));

    // Stalled Teak: count saturates at DEPTH, head word held
    resp_en = 1'b0;
    @(negedge clk);
    base = accepted;
    low  = delivered;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_data = 8'(8'h40 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stall_accepted", 32'(accepted - base), 32'(DEPTH));
    chk("stall_out_req", 32'(out_req), 32'(1));
    chk("stall_in_ready", 32'(in_ready), 32'(0));
    chk("stall_out_data", 32'(out_data), 32'(8'h40));
    resp_en = 1'b1;
    wait_idle();
    chk("stall_delivered", 32'(delivered - low), 32'(DEPTH));

    // Reset while REQ_HI with two words queued
    resp_en = 1'b0;
    @(negedge clk);
    push_word(8'h55);
    push_word(8'h66);
    wait_req(1'b1);
    chk("prerst_busy", 32'(busy), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_out_req", 32'(out_req), 32'(0));
    chk("rst_async_out_data", 32'(out_data), 32'(0));
    chk("rst_async_busy", 32'(busy), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 32'(busy), 32'(0));
    chk("postrst_proto_err", 32'(proto_err), 32'(0));
    chk("postrst_out_data", 32'(out_data), 32'(0));
    chk("postrst_in_ready", 32'(in_ready), 32'(1));
    chk("postrst_out_req", 32'(out_req), 32'(0));

    // Pointer wrap: random gaps and random Teak turnaround
    resp_en   = 1'b1;
    resp_rand = 1'b1;
    base = delivered;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_word(8'(8'h10 + i));
    end
    wait_idle();
    chk("wrap_delivered", 32'(delivered - base), 32'(10));
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("wrap_proto_err", 32'(proto_err), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
